// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: parses SPI command frames into buffered pixel writes and register updates.
// Optional feature: define CMD_AUTO_SWAP_EN to flip frame_buffer_select after each pixel frame.
module spi_cmd_decoder #(
    parameter int ADDRESS_WIDTH = 14,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     cs_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_wr,
    output logic [7:0]               mem_data,
    output logic                     mem_data_ready,
    input  logic                     mem_fifo_full,
    output logic                     frame_buffer_select,
    output logic [7:0]               brightness,
    output logic                     cmd_error,
    output logic                     overflow
);
    localparam int          AW         = ADDRESS_WIDTH;
    localparam int          PW         = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR_HI = 3'd1;
    localparam logic [2:0] ST_ADDR_LO = 3'd2;
    localparam logic [2:0] ST_DATA    = 3'd3;
    localparam logic [2:0] ST_REG_ARG = 3'd4;
    localparam logic [2:0] ST_DISCARD = 3'd5;

    logic          cs_meta_q, cs_meta_d;
    logic          cs_sync_q, cs_sync_d;
    logic          cs_prev_q, cs_prev_d;
    logic          cs_rise, rx_accept;

    logic [2:0]    state_q, state_d;
    logic [7:0]    addr_hi_q, addr_hi_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          target_bright_q, target_bright_d;

    logic [AW-1:0] fifo_addr_mem [FIFO_DEPTH];
    logic [7:0]    fifo_data_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          push, pop, fifo_full, fifo_empty;

    logic [AW-1:0] mem_address_q, mem_address_d;
    logic [7:0]    mem_data_q, mem_data_d;
    logic          strobe_q, strobe_d;
    logic          fsel_q, fsel_d;
    logic [7:0]    bright_q, bright_d;
    logic          cmd_error_q, cmd_error_d;
    logic          overflow_q, overflow_d;
`ifdef CMD_AUTO_SWAP_EN
    logic          has_data_q, has_data_d;
    logic          swap_pending_q, swap_pending_d;
`endif

    always_comb begin
        cs_meta_d       = cs_n;
        cs_sync_d       = cs_meta_q;
        cs_prev_d       = cs_sync_q;
        cs_rise         = cs_sync_q & ~cs_prev_q;
        rx_accept       = rx_valid & ~cs_sync_q;

        fifo_empty      = (count_q == '0);
        fifo_full       = (count_q == FULL_COUNT);
        pop             = ~fifo_empty & ~mem_fifo_full;
        push            = 1'b0;

        state_d         = state_q;
        addr_hi_d       = addr_hi_q;
        addr_d          = addr_q;
        target_bright_d = target_bright_q;
        fsel_d          = fsel_q;
        bright_d        = bright_q;
        cmd_error_d     = cmd_error_q;
        overflow_d      = overflow_q;

        if (cs_rise) begin
            state_d = ST_IDLE;
        end else if (rx_accept) begin
            case (state_q)
                ST_IDLE: begin
                    case (rx_data)
                        8'h01: state_d = ST_ADDR_HI;
                        8'h02: begin
                            state_d         = ST_REG_ARG;
                            target_bright_d = 1'b0;
                        end
                        8'h03: begin
                            state_d         = ST_REG_ARG;
                            target_bright_d = 1'b1;
                        end
                        default: begin
                            state_d     = ST_DISCARD;
                            cmd_error_d = 1'b1;
                        end
                    endcase
                end
                ST_ADDR_HI: begin
                    addr_hi_d = rx_data;
                    state_d   = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    addr_d  = AW'({addr_hi_q, rx_data});
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
                    if (!fifo_full || pop) begin
                        push = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    addr_d = addr_q + 1'b1;
                end
                ST_REG_ARG: begin
                    if (target_bright_q) begin
                        bright_d = rx_data;
                    end else begin
                        fsel_d = rx_data[0];
                    end
                    state_d = ST_DISCARD;
                end
                default: ;
            endcase
        end

`ifdef CMD_AUTO_SWAP_EN
        has_data_d     = has_data_q | push;
        swap_pending_d = swap_pending_q;
        if (cs_rise) begin
            has_data_d = 1'b0;
            if (has_data_q) begin
                swap_pending_d = 1'b1;
            end
        end else if (swap_pending_q && fifo_empty) begin
            // Waiting for an empty FIFO keeps the swap behind the frame's final write.
            fsel_d         = ~fsel_d;
            swap_pending_d = 1'b0;
        end
`endif

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        mem_address_d = pop ? fifo_addr_mem[rd_ptr_q] : mem_address_q;
        mem_data_d    = pop ? fifo_data_mem[rd_ptr_q] : mem_data_q;
        strobe_d      = pop;
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_q] <= addr_q;
            fifo_data_mem[wr_ptr_q] <= rx_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            cs_meta_q       <= 1'b1;
            cs_sync_q       <= 1'b1;
            cs_prev_q       <= 1'b1;
            state_q         <= ST_IDLE;
            addr_hi_q       <= '0;
            addr_q          <= '0;
            target_bright_q <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            mem_address_q   <= '0;
            mem_data_q      <= '0;
            strobe_q        <= 1'b0;
            fsel_q          <= 1'b0;
            bright_q        <= 8'hFF;
            cmd_error_q     <= 1'b0;
            overflow_q      <= 1'b0;
`ifdef CMD_AUTO_SWAP_EN
            has_data_q      <= 1'b0;
            swap_pending_q  <= 1'b0;
`endif
        end else begin
            cs_meta_q       <= cs_meta_d;
            cs_sync_q       <= cs_sync_d;
            cs_prev_q       <= cs_prev_d;
            state_q         <= state_d;
            addr_hi_q       <= addr_hi_d;
            addr_q          <= addr_d;
            target_bright_q <= target_bright_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            mem_address_q   <= mem_address_d;
            mem_data_q      <= mem_data_d;
            strobe_q        <= strobe_d;
            fsel_q          <= fsel_d;
            bright_q        <= bright_d;
            cmd_error_q     <= cmd_error_d;
            overflow_q      <= overflow_d;
`ifdef CMD_AUTO_SWAP_EN
            has_data_q      <= has_data_d;
            swap_pending_q  <= swap_pending_d;
`endif
        end
    end

    assign mem_address         = mem_address_q;
    assign mem_data            = mem_data_q;
    assign mem_wr              = strobe_q;
    assign mem_data_ready      = strobe_q;
    assign frame_buffer_select = fsel_q;
    assign brightness          = bright_q;
    assign cmd_error           = cmd_error_q;
    assign overflow            = overflow_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Testbench for spi_cmd_decoder: directed frames plus randomized frames against a frame-level model.
// Builds with or without CMD_AUTO_SWAP_EN; the model follows the same macro.
module tb_spi_cmd_decoder;
    localparam int AW = 14;
    localparam int FD = 4;

    typedef logic [7:0] frame_t[$];

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          cs_n = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          mem_fifo_full;
    logic [AW-1:0] mem_address;
    logic          mem_wr;
    logic [7:0]    mem_data;
    logic          mem_data_ready;
    logic          frame_buffer_select;
    logic [7:0]    brightness;
    logic          cmd_error;
    logic          overflow;

    logic bp_force = 1'b0;
    logic bp_en    = 1'b0;
    logic bp_rand  = 1'b0;
    assign mem_fifo_full = bp_force | bp_rand;

    spi_cmd_decoder #(.ADDRESS_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .cs_n(cs_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_address(mem_address), .mem_wr(mem_wr), .mem_data(mem_data),
        .mem_data_ready(mem_data_ready), .mem_fifo_full(mem_fifo_full),
        .frame_buffer_select(frame_buffer_select), .brightness(brightness),
        .cmd_error(cmd_error), .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    int unsigned exp_q[$];
    int unsigned obs_q[$];
    logic        mon_en = 1'b0;
    logic        exp_fsel = 1'b0;
    logic [7:0]  exp_bright = 8'hFF;
    logic        exp_err = 1'b0;
    logic        exp_ovf = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (mon_en && mem_data_ready === 1'b1) begin
            obs_q.push_back(32'({mem_address, mem_data}));
            check_eq("mem_wr_qual", 32'(mem_wr), 32'd1);
        end
    end

    always @(posedge clk_sys) begin
        #2;
        bp_rand = bp_en && ($urandom_range(0, 1) == 1);
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (3) step();
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        repeat (4) step();
    endtask

    // Frame-level reference: what a whole frame should do to memory and registers.
    task automatic model_frame(input frame_t f);
        int unsigned start;
        if (f.size() == 0) return;
        case (f[0])
            8'h01: begin
                if (f.size() >= 3) begin
                    start = {16'd0, f[1], f[2]} % (1 << AW);
                    for (int i = 3; i < f.size(); i++)
                        exp_q.push_back(((start + i - 3) % (1 << AW)) * 256 + f[i]);
`ifdef CMD_AUTO_SWAP_EN
                    if (f.size() > 3) exp_fsel = ~exp_fsel;
`endif
                end
            end
            8'h02: if (f.size() >= 2) exp_fsel = f[1][0];
            8'h03: if (f.size() >= 2) exp_bright = f[1];
            default: exp_err = 1'b1;
        endcase
    endtask

    task automatic check_regs(input string tag);
        check_eq($sformatf("%s_fsel", tag), 32'(frame_buffer_select), 32'(exp_fsel));
        check_eq($sformatf("%s_bright", tag), 32'(brightness), 32'(exp_bright));
        check_eq($sformatf("%s_cmd_error", tag), 32'(cmd_error), 32'(exp_err));
        check_eq($sformatf("%s_overflow", tag), 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic drain_and_compare(input string tag);
        int budget = 300;
        bp_en = 1'b0;
        while (obs_q.size() < exp_q.size() && budget > 0) begin
            step();
            budget--;
        end
        repeat (6) step();
        check_eq($sformatf("%s_nwrites", tag), 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check_eq($sformatf("%s_write", tag), obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic run_frame(input frame_t f, input bit rnd, input string tag);
        if (rnd) send_byte(8'($urandom));   // cs_n high: must be ignored
        cs_low();
        bp_en = rnd;
        foreach (f[i]) begin
            send_byte(f[i]);
            if (rnd) repeat ($urandom_range(0, 2)) step();
        end
        cs_high();
        model_frame(f);
        drain_and_compare(tag);
        check_regs(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f;
        int     r;

        // Reset state
        repeat (3) step();
        check_eq("rst_strobe", 32'(mem_data_ready), 32'd0);
        check_eq("rst_wr", 32'(mem_wr), 32'd0);
        check_eq("rst_addr", 32'(mem_address), 32'd0);
        check_eq("rst_data", 32'(mem_data), 32'd0);
        check_regs("rst");
        reset_n = 1'b1;
        step();
        mon_en = 1'b1;

        // Latency and back-to-back writes
        f = {8'h01, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC};
        cs_low();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
        rx_data = 8'hAA; rx_valid = 1'b1; step();
        check_eq("lat_n1_strobe", 32'(mem_data_ready), 32'd0);
        rx_data = 8'hBB; step();
        check_eq("lat_n2_strobe", 32'(mem_data_ready), 32'd1);
        check_eq("lat_n2_addr", 32'(mem_address), 32'h10);
        check_eq("lat_n2_data", 32'(mem_data), 32'hAA);
        rx_data = 8'hCC; step();
        rx_valid = 1'b0;
        check_eq("seq2_addr", 32'(mem_address), 32'h11);
        check_eq("seq2_data", 32'(mem_data), 32'hBB);
        step();
        check_eq("seq3_strobe", 32'(mem_data_ready), 32'd1);
        check_eq("seq3_addr", 32'(mem_address), 32'h12);
        check_eq("seq3_data", 32'(mem_data), 32'hCC);
        step();
        check_eq("seq_end_strobe", 32'(mem_data_ready), 32'd0);
        check_eq("hold_addr", 32'(mem_address), 32'h12);
        cs_high();
        model_frame(f);
        drain_and_compare("t1");
        check_regs("t1");

        // Address wrap
        f = {8'h01, 8'h3F, 8'hFF, 8'h11, 8'h22};
        run_frame(f, 1'b0, "wrap");

        // Register writes, immediate visibility, unknown opcode
        f = {8'h02, 8'h01};
        run_frame(f, 1'b0, "fb");
        cs_low();
        send_byte(8'h03);
        send_byte(8'h40);
        check_eq("bright_next_cycle", 32'(brightness), 32'h40);
        cs_high();
        f = {8'h03, 8'h40};
        model_frame(f);
        check_regs("bright");
        f = {8'h7E, 8'h01};
        run_frame(f, 1'b0, "badop");

        // Frame cut short after one address byte
        f = {8'h01, 8'h00};
        cs_low();
        send_byte(8'h01); send_byte(8'h00);
        cs_high();
        model_frame(f);
        f = {8'h02, 8'h00};
        run_frame(f, 1'b0, "after_short");

        // Pixel frame with data, then an empty pixel frame
        f = {8'h01, 8'h00, 8'h00, 8'h55};
        run_frame(f, 1'b0, "swap_data");
        f = {8'h01, 8'h00, 8'h00};
        run_frame(f, 1'b0, "swap_empty");

        // Back-pressure, overflow, address keeps counting over dropped bytes
        obs_q.delete();
        bp_force = 1'b1;
        cs_low();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h20);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h30 + i));
        repeat (2) step();
        check_eq("bp_overflow", 32'(overflow), 32'd1);
        check_eq("bp_no_strobe", 32'(obs_q.size()), 32'd0);
        bp_force = 1'b0;
        for (int i = 0; i < FD; i++) begin
            step();
            check_eq("bp_drain_strobe", 32'(mem_data_ready), 32'd1);
            check_eq("bp_drain_addr", 32'(mem_address), 32'(32'h20 + i));
            check_eq("bp_drain_data", 32'(mem_data), 32'(32'h30 + i));
        end
        step();
        check_eq("bp_drain_end", 32'(mem_data_ready), 32'd0);
        send_byte(8'h77);
        step();
        check_eq("bp_skip_addr", 32'(mem_address), 32'h26);
        check_eq("bp_skip_data", 32'(mem_data), 32'h77);
        cs_high();
        exp_ovf = 1'b1;
`ifdef CMD_AUTO_SWAP_EN
        exp_fsel = ~exp_fsel;
`endif
        repeat (3) step();
        obs_q.delete();
        check_regs("bp");

        // Reset in the middle of a data phase
        cs_low();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hAA);
        reset_n = 1'b0;
        step();
        check_eq("mid_rst_strobe", 32'(mem_data_ready), 32'd0);
        check_eq("mid_rst_addr", 32'(mem_address), 32'd0);
        check_eq("mid_rst_data", 32'(mem_data), 32'd0);
        exp_fsel = 1'b0; exp_bright = 8'hFF; exp_err = 1'b0; exp_ovf = 1'b0;
        check_regs("mid_rst");
        reset_n = 1'b1;
        cs_high();
        repeat (5) step();
        check_eq("mid_rst_flushed", 32'(obs_q.size()), 32'd0);
        obs_q.delete();
        exp_q.delete();

        // Randomized frames with random back-pressure and byte gaps
        for (int n = 0; n < 40; n++) begin
            f = {};
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                f.push_back(8'h01);
                if ($urandom_range(0, 3) == 0) begin
                    f.push_back(8'h3F);
                    f.push_back(8'($urandom_range(8'hFC, 8'hFF)));
                end else begin
                    f.push_back(8'($urandom));
                    f.push_back(8'($urandom));
                end
                repeat ($urandom_range(0, FD)) f.push_back(8'($urandom));
            end else if (r <= 6) begin
                f.push_back(8'h02);
                repeat ($urandom_range(1, 3)) f.push_back(8'($urandom));
            end else if (r == 7) begin
                f.push_back(8'h03);
                repeat ($urandom_range(1, 3)) f.push_back(8'($urandom));
            end else if (r == 8) begin
                f.push_back(8'($urandom_range(4, 255)));
                repeat ($urandom_range(0, 2)) f.push_back(8'($urandom));
            end else begin
                f.push_back(8'h01);
                repeat ($urandom_range(0, 2)) f.push_back(8'($urandom));
            end
            run_frame(f, 1'b1, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
